// File: rtl/enemy_pkg.sv
// Shared types, screen constants and helpers for the enemy swarm.
package enemy_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // x/y hold signed 11-bit screen coordinates; speed is already forced non-zero.
    typedef struct packed {
        logic        active;
        dir_e        dir;
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  speed;
    } slot_t;

    // A 10-bit lane is below 1024, so two conditional subtractions give lane % span.
    function automatic logic [9:0] lane_wrap(input logic [9:0] lane, input logic [9:0] span);
        logic [9:0] v;
        v = lane;
        if (v >= span) begin
            v = v - span;
        end
        if (v >= span) begin
            v = v - span;
        end
        return v;
    endfunction

    // Sprite artwork: top bit set so every sprite texel is opaque.
    function automatic logic [11:0] rom_word(input logic [10:0] addr);
        return {1'b1, addr};
    endfunction

endpackage

// File: rtl/enemy_ROM.sv
// Sprite colour ROM, one registered read per pixel clock.
module enemy_ROM
    import enemy_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [11:0]       data_o
);

    logic [11:0] data_q;

    // Synchronous read
    always_ff @(posedge clk_i) begin
        data_q <= rom_word(11'(addr_i));
    end

    assign data_o = data_q;

endmodule

// File: rtl/enemy_sprite_addr.sv
// Per-slot hit test and orientation-aware ROM address generation.
module enemy_sprite_addr
    import enemy_pkg::*;
#(
    parameter int SPR_W   = 8,
    parameter int SPR_LEN = 48,
    parameter int ADDR_W  = 9
) (
    input  logic              active_i,
    input  dir_e              dir_i,
    input  logic [10:0]       pos_x_i,
    input  logic [10:0]       pos_y_i,
    input  logic [10:0]       draw_x_i,
    input  logic [10:0]       draw_y_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic signed [12:0] W13   = 13'(SPR_W);
    localparam logic signed [12:0] LEN13 = 13'(SPR_LEN);
    localparam logic [ADDR_W-1:0]  WA    = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0]  LENA  = ADDR_W'(SPR_LEN);
    localparam logic [ADDR_W-1:0]  ONEA  = ADDR_W'(1);

    logic signed [12:0] dx_s, dy_s, wide_s, tall_s;
    logic [ADDR_W-1:0]  dxa_s, dya_s, raw_s;
    logic               vert_s;

    // Footprint test and texel address; DOWN/UP read the right-facing art rotated
    always_comb begin
        dx_s   = $signed({2'b00, draw_x_i}) - $signed({{2{pos_x_i[10]}}, pos_x_i});
        dy_s   = $signed({2'b00, draw_y_i}) - $signed({{2{pos_y_i[10]}}, pos_y_i});
        vert_s = (dir_i == DIR_DOWN) || (dir_i == DIR_UP);
        wide_s = vert_s ? W13 : LEN13;
        tall_s = vert_s ? LEN13 : W13;
        hit_o  = active_i && (dx_s >= 13'sd0) && (dx_s < wide_s)
                          && (dy_s >= 13'sd0) && (dy_s < tall_s);
        dxa_s  = ADDR_W'(dx_s);
        dya_s  = ADDR_W'(dy_s);
        case (dir_i)
            DIR_RIGHT: raw_s = dxa_s + LENA * dya_s;
            DIR_LEFT:  raw_s = (LENA - ONEA - dxa_s) + LENA * dya_s;
            DIR_DOWN:  raw_s = dya_s + LENA * (WA - ONEA - dxa_s);
            DIR_UP:    raw_s = (LENA - ONEA - dya_s) + LENA * (WA - ONEA - dxa_s);
            default:   raw_s = {ADDR_W{1'b0}};
        endcase
        if (hit_o) begin
            addr_o = raw_s;
        end else begin
            addr_o = {ADDR_W{1'b0}};
        end
    end

endmodule

// File: rtl/enemy_swarm.sv
// N-slot enemy manager: spawn allocation, per-frame movement sweep, priority render.
// Optional player collision is built when ENEMY_SWARM_COLLIDE_EN is defined.
module enemy_swarm
    import enemy_pkg::*;
#(
    parameter int N_ENEMIES = 8,
    parameter int SPR_W     = 8,
    parameter int SPR_LEN   = 48,
    parameter int ADDR_W    = 9
) (
    input  logic                 pixel_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 frame_tick,
    input  logic                 spawn_req,
    input  logic [1:0]           spawn_dir,
    input  logic [9:0]           spawn_lane,
    input  logic [3:0]           spawn_speed,
    output logic                 spawn_ack,
    output logic                 full,
    output logic                 busy,
    output logic [N_ENEMIES-1:0] live_mask,
    input  logic [10:0]          drawX,
    input  logic [10:0]          drawY,
    output logic [11:0]          enemy_color
`ifdef ENEMY_SWARM_COLLIDE_EN
    ,
    input  logic [10:0]          player_x,
    input  logic [10:0]          player_y,
    input  logic [7:0]           player_w,
    input  logic [7:0]           player_h,
    output logic                 collide
`endif
);

    localparam int IDX_W = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_ENEMIES - 1);
    localparam logic signed [12:0] LEN13    = 13'(SPR_LEN);
    localparam logic signed [12:0] W13      = 13'(SPR_W);
    localparam logic signed [12:0] SCR_W13  = 13'(SCREEN_W);
    localparam logic signed [12:0] SCR_H13  = 13'(SCREEN_H);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              busy_q;
    slot_t             slots_q [N_ENEMIES];

    logic              free_found_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic              spawn_go_s;
    slot_t             spawn_slot_s;
    slot_t             cur_s;
    slot_t             step_s;
    logic signed [12:0] mv_x_s, mv_y_s, spd_s;
    logic              vert_s, off_s, ovl_s;

    logic [N_ENEMIES-1:0] hit_s;
    logic [ADDR_W-1:0]    addr_s [N_ENEMIES];
    logic                 sel_hit_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic                 hit_q;
    logic [11:0]          rom_data_s;

    // Lowest free slot and live flags
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = {IDX_W{1'b0}};
        live_mask    = {N_ENEMIES{1'b0}};
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            live_mask[i] = slots_q[i].active;
            if (!slots_q[i].active) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    assign full       = !free_found_s;
    // A tick in the same cycle takes precedence; the request simply waits.
    assign spawn_go_s = (state_q == ST_IDLE) && en && !frame_tick && spawn_req && free_found_s;
    assign spawn_ack  = spawn_go_s;
    assign busy       = busy_q;

    // Entry position of a newly spawned slot
    always_comb begin
        spawn_slot_s        = '0;
        spawn_slot_s.active = 1'b1;
        spawn_slot_s.dir    = dir_e'(spawn_dir);
        spawn_slot_s.speed  = (spawn_speed == 4'd0) ? 4'd1 : spawn_speed;
        case (dir_e'(spawn_dir))
            DIR_DOWN: begin
                spawn_slot_s.x = {1'b0, lane_wrap(spawn_lane, 10'(SCREEN_W))};
                spawn_slot_s.y = 11'(-LEN13);
            end
            DIR_UP: begin
                spawn_slot_s.x = {1'b0, lane_wrap(spawn_lane, 10'(SCREEN_W))};
                spawn_slot_s.y = 11'(SCR_H13);
            end
            DIR_RIGHT: begin
                spawn_slot_s.x = 11'(-LEN13);
                spawn_slot_s.y = {1'b0, lane_wrap(spawn_lane, 10'(SCREEN_H))};
            end
            DIR_LEFT: begin
                spawn_slot_s.x = 11'(SCR_W13);
                spawn_slot_s.y = {1'b0, lane_wrap(spawn_lane, 10'(SCREEN_H))};
            end
            default: begin
                spawn_slot_s.x = 11'd0;
                spawn_slot_s.y = 11'd0;
            end
        endcase
    end

    // Move the slot under the sweep pointer and decide whether it survives
    always_comb begin
        cur_s  = slots_q[idx_q];
        mv_x_s = $signed({{2{cur_s.x[10]}}, cur_s.x});
        mv_y_s = $signed({{2{cur_s.y[10]}}, cur_s.y});
        spd_s  = $signed({9'd0, cur_s.speed});
        vert_s = (cur_s.dir == DIR_DOWN) || (cur_s.dir == DIR_UP);
        case (cur_s.dir)
            DIR_DOWN:  mv_y_s = mv_y_s + spd_s;
            DIR_UP:    mv_y_s = mv_y_s - spd_s;
            DIR_RIGHT: mv_x_s = mv_x_s + spd_s;
            DIR_LEFT:  mv_x_s = mv_x_s - spd_s;
            default:   mv_x_s = mv_x_s;
        endcase
        if (vert_s) begin
            off_s = (mv_y_s <= -LEN13) || (mv_y_s >= SCR_H13);
        end else begin
            off_s = (mv_x_s <= -LEN13) || (mv_x_s >= SCR_W13);
        end
        step_s        = cur_s;
        step_s.x      = mv_x_s[10:0];
        step_s.y      = mv_y_s[10:0];
        step_s.active = cur_s.active && !off_s && !ovl_s;
    end

`ifdef ENEMY_SWARM_COLLIDE_EN
    logic signed [12:0] px_s, py_s, pw_s, ph_s, ew_s, eh_s;
    logic               pulsed_q;
    logic               collide_q;

    // Post-move enemy box against the player box
    always_comb begin
        px_s  = $signed({2'b00, player_x});
        py_s  = $signed({2'b00, player_y});
        pw_s  = $signed({5'd0, player_w});
        ph_s  = $signed({5'd0, player_h});
        ew_s  = vert_s ? W13 : LEN13;
        eh_s  = vert_s ? LEN13 : W13;
        ovl_s = cur_s.active && (mv_x_s < px_s + pw_s) && (px_s < mv_x_s + ew_s)
                             && (mv_y_s < py_s + ph_s) && (py_s < mv_y_s + eh_s);
    end

    // Single collide pulse per sweep
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            collide_q <= 1'b0;
            pulsed_q  <= 1'b0;
        end else begin
            collide_q <= (state_q == ST_SWEEP) && en && ovl_s && !pulsed_q;
            if (state_q == ST_IDLE) begin
                pulsed_q <= 1'b0;
            end else if ((state_q == ST_SWEEP) && en && ovl_s) begin
                pulsed_q <= 1'b1;
            end
        end
    end

    assign collide = collide_q;
`else
    assign ovl_s = 1'b0;
`endif

    // Sweep FSM, slot storage and spawn writes
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            busy_q  <= 1'b0;
            for (int i = 0; i < N_ENEMIES; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick && en) begin
                        state_q <= ST_SWEEP;
                        idx_q   <= {IDX_W{1'b0}};
                        busy_q  <= 1'b1;
                    end else if (spawn_go_s) begin
                        slots_q[free_idx_s] <= spawn_slot_s;
                    end
                end
                ST_SWEEP: begin
                    if (en) begin
                        slots_q[idx_q] <= step_s;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_ENEMIES; g++) begin : g_spr
        enemy_sprite_addr #(
            .SPR_W   (SPR_W),
            .SPR_LEN (SPR_LEN),
            .ADDR_W  (ADDR_W)
        ) u_addr (
            .active_i (slots_q[g].active),
            .dir_i    (slots_q[g].dir),
            .pos_x_i  (slots_q[g].x),
            .pos_y_i  (slots_q[g].y),
            .draw_x_i (drawX),
            .draw_y_i (drawY),
            .hit_o    (hit_s[g]),
            .addr_o   (addr_s[g])
        );
    end

    // Lowest-index hit owns the pixel
    always_comb begin
        sel_hit_s  = 1'b0;
        sel_addr_s = {ADDR_W{1'b0}};
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                sel_hit_s  = 1'b1;
                sel_addr_s = addr_s[i];
            end else begin
                sel_hit_s  = sel_hit_s;
            end
        end
    end

    enemy_ROM #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk_i  (pixel_clk),
        .addr_i (sel_addr_s),
        .data_o (rom_data_s)
    );

    // Hit flag delayed to line up with the ROM read
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= sel_hit_s;
        end
    end

    assign enemy_color = hit_q ? rom_data_s : 12'h000;

endmodule

// File: tb/tb_enemy_swarm.sv
// Directed bench for enemy_swarm; sprite art is expected as 12'h800 | address.
module tb_enemy_swarm;

    logic        pixel_clk = 1'b0;
    logic        rst, en, frame_tick, spawn_req;
    logic [1:0]  spawn_dir;
    logic [9:0]  spawn_lane;
    logic [3:0]  spawn_speed;
    logic        spawn_ack, full, busy;
    logic [7:0]  live_mask;
    logic [10:0] drawX, drawY;
    logic [11:0] enemy_color;
`ifdef ENEMY_SWARM_COLLIDE_EN
    logic [10:0] player_x, player_y;
    logic [7:0]  player_w, player_h;
    logic        collide;
    int          collide_seen = 0;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int ack_seen = 0;

    always #5 pixel_clk = ~pixel_clk;

    enemy_swarm dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .en          (en),
        .frame_tick  (frame_tick),
        .spawn_req   (spawn_req),
        .spawn_dir   (spawn_dir),
        .spawn_lane  (spawn_lane),
        .spawn_speed (spawn_speed),
        .spawn_ack   (spawn_ack),
        .full        (full),
        .busy        (busy),
        .live_mask   (live_mask),
        .drawX       (drawX),
        .drawY       (drawY),
        .enemy_color (enemy_color)
`ifdef ENEMY_SWARM_COLLIDE_EN
        ,
        .player_x    (player_x),
        .player_y    (player_y),
        .player_w    (player_w),
        .player_h    (player_h),
        .collide     (collide)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse frame_tick and count busy cycles; returns at the first idle negedge.
    task automatic do_tick(output int cyc);
        frame_tick = 1'b1;
        @(negedge pixel_clk);
        frame_tick = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            if (spawn_ack) ack_seen++;
`ifdef ENEMY_SWARM_COLLIDE_EN
            if (collide) collide_seen++;
`endif
            @(negedge pixel_clk);
        end
    endtask

    task automatic do_spawn(input logic [1:0] d, input logic [9:0] lane, input logic [3:0] spd,
                            output logic acked);
        int waited;
        spawn_dir   = d;
        spawn_lane  = lane;
        spawn_speed = spd;
        spawn_req   = 1'b1;
        waited      = 0;
        #1;
        while (!spawn_ack && waited < 60) begin
            @(negedge pixel_clk);
            #1;
            waited++;
        end
        acked = spawn_ack;
        @(negedge pixel_clk);
        spawn_req = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [10:0] x, input logic [10:0] y,
                       input logic [11:0] exp);
        drawX = x;
        drawY = y;
        @(negedge pixel_clk);
        check(tag, 32'(enemy_color), 32'(exp));
    endtask

    initial begin
        int   cyc;
        logic ok;
        rst = 1'b1; en = 1'b1; frame_tick = 1'b0; spawn_req = 1'b0;
        spawn_dir = 2'd0; spawn_lane = 10'd0; spawn_speed = 4'd0;
        drawX = 11'd0; drawY = 11'd0;
`ifdef ENEMY_SWARM_COLLIDE_EN
        player_x = 11'd2000; player_y = 11'd2000; player_w = 8'd0; player_h = 8'd0;
`endif
        repeat (3) @(negedge pixel_clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_live", 32'(live_mask), 32'd0);
        check("rst_ack", 32'(spawn_ack), 32'd0);
        check("rst_color", 32'(enemy_color), 32'd0);
        rst = 1'b0;
        @(negedge pixel_clk);

        // DOWN lane 100 speed 2: 30 frames -> y = 12
        do_spawn(2'd0, 10'd100, 4'd2, ok);
        check("down_ack", 32'(ok), 32'd1);
        check("down_live", 32'(live_mask), 32'h01);
        do_tick(cyc);
        check("busy_len", 32'(cyc), 32'd8);
        for (int i = 1; i < 30; i++) do_tick(cyc);
        pix("down_origin", 11'd100, 11'd12, 12'h950);
        pix("down_dx7", 11'd107, 11'd12, 12'h800);
        pix("down_tail", 11'd100, 11'd59, 12'h97F);
        pix("down_above", 11'd100, 11'd11, 12'h000);
        pix("down_right", 11'd108, 11'd12, 12'h000);
        pix("down_below", 11'd100, 11'd60, 12'h000);

        // RIGHT lane 200 speed 5: x = 637 after 137 frames, 642 (gone) after 138
        do_spawn(2'd2, 10'd200, 4'd5, ok);
        check("right_ack", 32'(ok), 32'd1);
        check("right_live", 32'(live_mask), 32'h03);
        for (int i = 0; i < 137; i++) do_tick(cyc);
        check("right_alive637", 32'(live_mask), 32'h03);
        pix("right_origin", 11'd637, 11'd200, 12'h800);
        pix("right_texel", 11'd639, 11'd207, 12'h952);
        do_tick(cyc);
        check("right_despawn", 32'(live_mask), 32'h01);

        // Tick and request in the same cycle: sweep first, ack in the first idle cycle
        spawn_dir = 2'd3; spawn_lane = 10'd50; spawn_speed = 4'd1; spawn_req = 1'b1;
        ack_seen = 0;
        do_tick(cyc);
        check("tie_busy_len", 32'(cyc), 32'd8);
        check("tie_no_early_ack", 32'(ack_seen), 32'd0);
        check("tie_ack_after", 32'(spawn_ack), 32'd1);
        @(negedge pixel_clk);
        spawn_req = 1'b0;
        check("tie_live", 32'(live_mask), 32'h03);

        // Fill remaining slots 2..7
        do_spawn(2'd1, 10'd100, 4'd1, ok);
        check("fill2_live", 32'(live_mask), 32'h07);
        do_spawn(2'd1, 10'd200, 4'd15, ok);
        do_spawn(2'd3, 10'd70, 4'd1, ok);
        do_spawn(2'd1, 10'd104, 4'd1, ok);
        do_spawn(2'd3, 10'd80, 4'd1, ok);
        do_spawn(2'd3, 10'd90, 4'd1, ok);
        check("fill_last_ack", 32'(ok), 32'd1);
        check("fill_live", 32'(live_mask), 32'hFF);
        check("fill_full", 32'(full), 32'd1);
        pix("prio_slot2", 11'd105, 11'd480, 12'h88F);
        pix("only_slot5", 11'd110, 11'd480, 12'h85F);
        pix("slot2_corner", 11'd100, 11'd480, 12'h97F);

        // Ninth request waits until slot 3 (UP speed 15) leaves on frame 36
        spawn_dir = 2'd0; spawn_lane = 10'd20; spawn_speed = 4'd3; spawn_req = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 35; i++) do_tick(cyc);
        check("full_no_ack", 32'(ack_seen), 32'd0);
        check("full_still", 32'(live_mask), 32'hFF);
        do_tick(cyc);
        check("free_busy_len", 32'(cyc), 32'd8);
        check("free_ack_first_idle", 32'(spawn_ack), 32'd1);
        @(negedge pixel_clk);
        spawn_req = 1'b0;
        check("refill_live", 32'(live_mask), 32'hFF);
        pix("slot2_moved", 11'd105, 11'd444, 12'h88F);

        // Asynchronous reset in the middle of a sweep
        frame_tick = 1'b1;
        @(negedge pixel_clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge pixel_clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_live", 32'(live_mask), 32'd0);
        check("mid_rst_color", 32'(enemy_color), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        @(negedge pixel_clk);
        rst = 1'b0;
        @(negedge pixel_clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Frozen: no sweep, no ack
        en = 1'b0;
        do_tick(cyc);
        check("frozen_no_sweep", 32'(cyc), 32'd0);
        do_spawn(2'd0, 10'd5, 4'd1, ok);
        check("frozen_no_ack", 32'(ok), 32'd0);
        check("frozen_live", 32'(live_mask), 32'd0);
        en = 1'b1;
        @(negedge pixel_clk);

        // Speed 0 moves as 1; lane 1000 wraps to y = 40
        do_spawn(2'd2, 10'd1000, 4'd0, ok);
        check("wrap_ack", 32'(ok), 32'd1);
        do_tick(cyc);
        pix("speed0_edge", 11'd0, 11'd40, 12'h82F);
        pix("speed0_beyond", 11'd1, 11'd40, 12'h000);
        pix("wrap_row_above", 11'd0, 11'd39, 12'h000);

`ifdef ENEMY_SWARM_COLLIDE_EN
        do_spawn(2'd0, 10'd300, 4'd2, ok);
        check("col_live_before", 32'(live_mask), 32'h03);
        player_x = 11'd300; player_y = 11'd0; player_w = 8'd8; player_h = 8'd8;
        collide_seen = 0;
        do_tick(cyc);
        check("col_pulse", 32'(collide_seen), 32'd1);
        check("col_freed", 32'(live_mask), 32'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
